pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl_sat_counter.sv | 27 ++
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall bus layout,
// per-stage hold patterns, FSM state encoding and the stall priority helper.
package pipe_ctrl_pkg;

    localparam int StallBus = 6;

    // Each pattern holds the requesting stage and everything upstream of it.
    localparam logic [StallBus-1:0] StallNone = 6'b000000;
    localparam logic [StallBus-1:0] StallId   = 6'b000111;
    localparam logic [StallBus-1:0] StallEx   = 6'b001111;
    localparam logic [StallBus-1:0] StallMem  = 6'b011111;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic {
        PC_RUN   = 1'b0,
        PC_DRAIN = 1'b1
    } pc_state_e;

    // Deepest stage wins: a MEM stall already covers anything EX or ID ask for.
    function automatic logic [StallBus-1:0] stall_prio(input logic id, input logic ex,
                                                        input logic mem);
        logic [StallBus-1:0] v;
        v = StallNone;
        if (mem)
            v = StallMem;
        else if (ex)
            v = StallEx;
        else if (id)
            v = StallId;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between the pipeline stages (master) and the sequencing
// controller (slave).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                stallreq_id;
    logic                stallreq_ex;
    logic                stallreq_mem;
    logic                excp_valid;
    logic                excp_is_eret;
    logic [31:0]         excp_vector;
    logic [31:0]         cp0_epc;
    logic [StallBus-1:0] stall;
    logic                flush;
    logic [31:0]         new_pc;
    logic                stall_timeout;
    logic [31:0]         stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_is_eret, excp_vector, cp0_epc,
        input  stall, flush, new_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_is_eret, excp_vector, cp0_epc,
        output stall, flush, new_pc, stall_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and parallel load; clear beats
// load, load beats increment, and the count sticks at all-ones.
module pipe_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests into a hold
// vector, turns MEM exceptions/ERET into a flush + redirect, then drains.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  ctrl
);

    localparam logic [3:0]  DrainLoad = 4'(DRAIN_CYCLES);
    localparam logic [15:0] WdLimit   = 16'(STALL_TIMEOUT - 1);

    pc_state_e           r_state;
    pc_state_e           w_state_nxt;
    logic [3:0]          r_drain_cnt;
    logic [3:0]          w_drain_nxt;
    logic [StallBus-1:0] w_stall;
    logic                w_flush;
    logic [31:0]         w_new_pc;
    logic                w_stall_any;
    logic [15:0]         w_wd_count;
    logic                r_timeout;
    logic [31:0]         w_cyc_count;
    logic                w_cyc_load;
    logic [31:0]         w_cyc_load_val;

    // Debug preload of the stall-cycle counter; tied off in the core.
    assign w_cyc_load     = 1'b0;
    assign w_cyc_load_val = ZeroWord;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PC_RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_stall     = StallNone;
        w_flush     = 1'b0;
        w_new_pc    = ZeroWord;
        if (rst) begin
            // Downstream registers are resetting too; keep holds honest, never flush.
            w_stall = stall_prio(ctrl.stallreq_id, ctrl.stallreq_ex, ctrl.stallreq_mem);
        end else if (r_state == PC_RUN) begin
            if (ctrl.excp_valid) begin
                w_flush     = 1'b1;
                w_new_pc    = ctrl.excp_is_eret ? ctrl.cp0_epc : ctrl.excp_vector;
                w_state_nxt = PC_DRAIN;
                w_drain_nxt = DrainLoad;
            end else begin
                w_stall = stall_prio(ctrl.stallreq_id, ctrl.stallreq_ex, ctrl.stallreq_mem);
            end
        end else begin
            // Requests now come from flushed slots; just count down.
            if (r_drain_cnt <= 4'd1) begin
                w_state_nxt = PC_RUN;
                w_drain_nxt = 4'd0;
            end else begin
                w_drain_nxt = r_drain_cnt - 4'd1;
            end
        end
    end

    assign w_stall_any = |w_stall;

    pipe_ctrl_sat_counter #(.WIDTH(16)) u_watchdog (
        .clk        (clk),
        .i_clr      (rst | ~w_stall_any | w_flush),
        .i_inc      (w_stall_any),
        .i_load     (1'b0),
        .i_load_val (16'h0000),
        .o_count    (w_wd_count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_timeout <= 1'b0;
        else if (w_stall_any && (w_wd_count == WdLimit))
            r_timeout <= 1'b1;
    end

    pipe_ctrl_sat_counter #(.WIDTH(32)) u_stall_cycles (
        .clk        (clk),
        .i_clr      (rst),
        .i_inc      (w_stall_any),
        .i_load     (w_cyc_load),
        .i_load_val (w_cyc_load_val),
        .o_count    (w_cyc_count)
    );

    assign ctrl.stall         = w_stall;
    assign ctrl.flush         = w_flush;
    assign ctrl.new_pc        = w_new_pc;
    assign ctrl.stall_timeout = r_timeout;
    assign ctrl.stall_cycles  = w_cyc_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int DC = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DRAIN_CYCLES(DC), .STALL_TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model state: remaining ignored cycles, consecutive stall run, flag, total.
    int          m_drain = 0;
    int          m_run   = 0;
    bit          m_to    = 1'b0;
    logic [31:0] m_cyc   = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input bit ex, input bit mem, input bit ev,
                         input bit er, input logic [31:0] vec, input logic [31:0] epc);
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.excp_valid   = ev;
        bus.excp_is_eret = er;
        bus.excp_vector  = vec;
        bus.cp0_epc      = epc;
    endtask

    function automatic logic [5:0] req_hold();
        if (bus.stallreq_mem) return 6'b011111;
        if (bus.stallreq_ex)  return 6'b001111;
        if (bus.stallreq_id)  return 6'b000111;
        return 6'b000000;
    endfunction

    // One clock: check everything visible now, then advance the model over the edge.
    task automatic cyc(input string tag);
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        es = 6'b0;
        ef = 1'b0;
        ep = 32'h0;
        if (rst) begin
            es = req_hold();
        end else if (m_drain == 0) begin
            if (bus.excp_valid) begin
                ef = 1'b1;
                ep = bus.excp_is_eret ? bus.cp0_epc : bus.excp_vector;
            end else begin
                es = req_hold();
            end
        end
        #1;
        chk({tag, ".stall"},   {26'b0, bus.stall},         {26'b0, es});
        chk({tag, ".flush"},   {31'b0, bus.flush},         {31'b0, ef});
        chk({tag, ".new_pc"},  bus.new_pc,                 ep);
        chk({tag, ".timeout"}, {31'b0, bus.stall_timeout}, {31'b0, m_to});
        chk({tag, ".cycles"},  bus.stall_cycles,           m_cyc);
        @(posedge clk);
        if (rst) begin
            m_drain = 0;
            m_run   = 0;
            m_to    = 1'b0;
            m_cyc   = 32'h0;
        end else if (ef) begin
            m_drain = DC;
            m_run   = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            m_run = 0;
        end else if (es != 6'b0) begin
            if (m_run + 1 >= TO) m_to = 1'b1;
            if (m_run < 65535) m_run++;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
        end else begin
            m_run = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        cyc("reset0");
        cyc("reset1");
        rst = 1'b0;
        repeat (10) cyc("idle");

        // Stall priority
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0); cyc("prio_id");
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0); cyc("prio_ex");
        drive(1, 1, 1, 0, 0, 32'h0, 32'h0);
        repeat (3) cyc("prio_mem");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); cyc("prio_off");
        chk("prio_total", bus.stall_cycles, 32'd5);

        // Exception overrides a MEM stall, then drain ignores requests and a 2nd exception
        drive(0, 0, 1, 1, 0, 32'hBFC00380, 32'h0); cyc("excp");
        cyc("drain_excp1");
        drive(0, 0, 1, 0, 0, 32'hBFC00380, 32'h0); cyc("drain2");
        cyc("post_drain");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); cyc("idle2");

        // ERET
        drive(0, 0, 0, 1, 1, 32'hBFC00380, 32'h00400020); cyc("eret");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        repeat (3) cyc("eret_drain");

        // Watchdog: 3+gap+3 never trips, 4 consecutive does, and it sticks
        rst = 1'b1; cyc("wd_rst"); rst = 1'b0;
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0); repeat (3) cyc("wd_a");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); cyc("wd_gap");
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0); repeat (3) cyc("wd_b");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); cyc("wd_gap2");
        chk("wd_no_trip", {31'b0, bus.stall_timeout}, 32'd0);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0); repeat (4) cyc("wd_c");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); repeat (3) cyc("wd_hold");
        chk("wd_sticky", {31'b0, bus.stall_timeout}, 32'd1);

        // Saturation via the preload hook
        force dut.w_cyc_load     = 1'b1;
        force dut.w_cyc_load_val = 32'hFFFF_FFFE;
        cyc("preload");
        release dut.w_cyc_load;
        release dut.w_cyc_load_val;
        m_cyc = 32'hFFFF_FFFE;
        drive(0, 0, 1, 0, 0, 32'h0, 32'h0); repeat (3) cyc("sat");
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); cyc("sat_idle");
        chk("sat_value", bus.stall_cycles, 32'hFFFF_FFFF);

        // Reset in the middle of a drain; next exception is taken at once
        drive(0, 0, 0, 1, 0, 32'h8000_0180, 32'h0); cyc("pre_rst_excp");
        rst = 1'b1;
        drive(0, 0, 1, 0, 0, 32'h0, 32'h0); cyc("rst_in_drain");
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 32'h8000_0180, 32'h0); cyc("after_rst_excp");
        chk("after_rst_cycles", bus.stall_cycles, 32'd0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0); repeat (3) cyc("after_rst_drain");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, $urandom, $urandom);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
